keypoint_collector: RTL
=======================

KEYPOINT_COLLECTOR -- requirements
Module: keypoint_collector

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- FRAME_W, 640, image width in pixels.
- FRAME_H, 480, image height in pixels.
- DEPTH, 64, keypoint FIFO entries; must be a power of two.
- BORDER, 2, minimum pix_x/pix_y at which a detection is valid.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; the pixel-pipeline clock.
- rst, in, 1, synchronous, active-high reset.
- en, in, 1, pixel strobe, same as the pixel pipeline enable.
- frame_rst, in, 1, frame-start strobe from the pixel coordinator reset.
- pix_x, in, 11, column of the newest pixel, aligned with ext_max/ext_min.
- pix_y, in, 11, row of the newest pixel.
- ext_max, in, 1, 3x3 local-maximum flag from the extremum stage.
- ext_min, in, 1, 3x3 local-minimum flag.
- score, in, 8, DoG x Harris offset value at the window centre.
- rd_req, in, 1, one-cycle pulse requesting the next readout byte (SPI byte strobe).
- rd_data, out, 8, readout byte.
- rd_valid, out, 1, one-cycle pulse qualifying rd_data.
- empty, out, 1, FIFO holds no entries.
- kp_count, out, 10, keypoints accepted this frame, saturating.
- overflow, out, 1, sticky per frame; a keypoint was dropped because the FIFO was full.

REQ-003 The block SHALL use one clock, clk, and a synchronous active-high reset, rst; there are no other clock or reset domains.

Function
REQ-004 The block SHALL treat a cycle as a capture when en=1, ext_max XOR ext_min = 1, pix_x>=BORDER, pix_y>=BORDER and frame_rst=0.
REQ-005 A cycle with both ext_max=1 and ext_min=1 SHALL be ignored.
REQ-006 A captured entry SHALL be {type=ext_max, X=pix_x-1, Y=pix_y-1, score}, i.e. the 3x3 window centre (32 bits per entry).
REQ-007 FIFO write and read pointers SHALL wrap modulo DEPTH; full means DEPTH entries are stored.
REQ-008 On a capture while the FIFO is full and no pop occurs in the same cycle, the entry SHALL be dropped and overflow set to 1.
REQ-009 On a capture while the FIFO is full and a pop occurs in the same cycle, the entry SHALL be accepted and no drop recorded.
REQ-010 kp_count SHALL increment by 1 per accepted entry and saturate at 1023.
REQ-011 frame_rst=1 SHALL clear kp_count and overflow to 0 the next cycle; FIFO contents and the readout FSM SHALL be unaffected.
REQ-012 The readout FSM SHALL have states IDLE, B1, B2, B3, B4.
- IDLE: rd_req with the FIFO non-empty pops the head into a shadow register, emits byte0, and moves to B1.
- B1..B4: each rd_req emits the next byte and advances; B4 returns to IDLE.
REQ-013 The byte order SHALL be as follows.
- byte0 = {type, 4'b0000, X[10:8]}
- byte1 = X[7:0]
- byte2 = {5'b00000, Y[10:8]}
- byte3 = Y[7:0]
- byte4 = score
REQ-014 rd_data SHALL be registered: for rd_req in cycle n, rd_data is valid and rd_valid=1 in cycle n+1 only, and rd_data holds its value until the next byte is emitted.
REQ-015 rd_req in IDLE with the FIFO empty SHALL emit rd_data=8'hFF with rd_valid=1 and leave the FSM in IDLE.
REQ-016 A capture and an IDLE pop in the same cycle with the FIFO empty SHALL follow REQ-015 and still store the new entry.
REQ-017 empty SHALL reflect the FIFO occupancy after the current cycle's write and pop, registered.
REQ-018 rd_req asserted while rd_valid=1 SHALL be serviced normally (back-to-back bytes allowed).

Reset
REQ-019 On rst=1 the block SHALL, on the next clk edge:
- empty the FIFO (pointers to 0);
- put the FSM in IDLE;
- set rd_data=8'hFF, rd_valid=0, empty=1, kp_count=0, overflow=0.
REQ-020 rst during B1..B4 SHALL discard the partially read entry.
REQ-021 rst SHALL take priority over frame_rst, capture and rd_req in the same cycle.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Single capture: en=1, ext_max=1, pix_x=10, pix_y=20, score=0x9A, then 5 rd_req pulses -> bytes 0x80, 0x09, 0x00, 0x13, 0x9A, then empty=1.
- Border: ext_min=1 at pix_x=1, pix_y=50 -> no entry, kp_count unchanged; at pix_x=2, pix_y=2 -> entry with X=1, Y=1, byte0=0x00.
- Overflow: 65 captures with no reads (DEPTH=64) -> kp_count=64, overflow=1; frame_rst -> kp_count=0, overflow=0, still 64 entries.
- Full with pop: FIFO full, IDLE pop and capture in the same cycle -> overflow stays 0, occupancy stays 64.
- Empty read: rd_req with empty=1 -> rd_data=0xFF, rd_valid=1 next cycle, FSM in IDLE; both flags high -> no entry stored.
- Mid-read reset: rst asserted in B2 with 3 entries stored -> empty=1, next rd_req returns 0xFF.

Source files
------------

// File: rtl/keypoint_collector.sv
// Keypoint collector: captures 3x3 extremum detections into a FIFO and streams
// each entry out as five bytes on a byte-strobe readout port.
module keypoint_collector #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int DEPTH   = 64,
  parameter int BORDER  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_rst,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        ext_max,
  input  logic        ext_min,
  input  logic [7:0]  score,
  input  logic        rd_req,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        empty,
  output logic [9:0]  kp_count,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypoint_collector: DEPTH must be a power of two");
  end
  if (FRAME_W > 2048 || FRAME_H > 2048) begin : g_bad_frame
    $error("keypoint_collector: frame does not fit 11-bit coordinates");
  end

  typedef struct packed {
    logic        kp_type;
    logic [10:0] x;
    logic [10:0] y;
    logic        rsvd;
    logic [7:0]  score;
  } entry_t;

  typedef enum logic [2:0] {IDLE, B1, B2, B3, B4} state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          new_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic [31:0]     shadow;
  state_t          state;
  logic            capture;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    capture = en && (ext_max ^ ext_min) && (pix_x >= 11'(BORDER)) &&
              (pix_y >= 11'(BORDER)) && !frame_rst;
    full    = (count == (AW+1)'(DEPTH));
    pop     = rd_req && (state == IDLE) && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
    head    = mem[rd_ptr];
    new_entry         = '0;
    new_entry.kp_type = ext_max;
    new_entry.x       = pix_x - 11'd1;
    new_entry.y       = pix_y - 11'd1;
    new_entry.score   = score;
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // NOTE: the storage array has no reset; count/pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      kp_count <= '0;
      overflow <= 1'b0;
      rd_data  <= 8'hFF;
      rd_valid <= 1'b0;
      shadow   <= '0;
      state    <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);

      if (frame_rst) begin
        kp_count <= '0;
        overflow <= 1'b0;
      end else begin
        if (push && kp_count != 10'd1023) kp_count <= kp_count + 10'd1;
        if (drop) overflow <= 1'b1;
      end

      rd_valid <= rd_req;
      if (rd_req) begin
        case (state)
          IDLE: begin
            if (pop) begin
              rd_data <= {head.kp_type, 4'b0000, head.x[10:8]};
              shadow  <= {head.x[7:0], 5'b00000, head.y[10:8], head.y[7:0], head.score};
              state   <= B1;
            end else begin
              rd_data <= 8'hFF;
            end
          end
          B1: begin
            rd_data <= shadow[31:24];
            shadow  <= shadow << 8;
            state   <= B2;
          end
          B2: begin
            rd_data <= shadow[31:24];
            shadow  <= shadow << 8;
            state   <= B3;
          end
          B3: begin
            rd_data <= shadow[31:24];
            shadow  <= shadow << 8;
            state   <= B4;
          end
          B4: begin
            rd_data <= shadow[31:24];
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
